// File: rtl/noc_rsc_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : noc_rsc_adapter                                              |
// | Description : Resource-side network interface for one local port of the   |
// |               2D-mesh XY NoC: buffered single-flit TX injection and a      |
// |               fall-through RX FIFO with full/overflow back-pressure.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module noc_rsc_adapter #(
  parameter  int ROW_N       = 3,
  parameter  int COL_M       = 3,
  parameter  int PCKT_DATA_W = 8,
  parameter  int TX_DEPTH_W  = 2,
  parameter  int RX_DEPTH_W  = 2,
  localparam int ROW_W       = $clog2(ROW_N),
  localparam int COL_W       = $clog2(COL_M),
  localparam int PCKT_W      = PCKT_DATA_W + ROW_W + COL_W
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // Resource TX side
  input  logic                   tx_valid_i,
  output logic                   tx_ready_o,
  input  logic [ROW_W-1:0]       tx_row_i,
  input  logic [COL_W-1:0]       tx_col_i,
  input  logic [PCKT_DATA_W-1:0] tx_data_i,
  // NoC local input
  output logic [PCKT_W-1:0]      noc_pckt_o,
  output logic                   noc_wren_o,
  input  logic                   noc_full_i,
  input  logic                   noc_ovrflw_i,
  // NoC local output
  input  logic [PCKT_W-1:0]      noc_pckt_i,
  input  logic                   noc_wren_i,
  output logic                   rsc_full_o,
  output logic                   rsc_ovrflw_o,
  // Resource RX side
  output logic                   rx_valid_o,
  input  logic                   rx_ready_i,
  output logic [PCKT_DATA_W-1:0] rx_data_o,
  output logic [ROW_W-1:0]       rx_row_o,
  output logic [COL_W-1:0]       rx_col_o,
  // Status
  output logic                   err_ovrflw_o
);

  localparam int TX_DEPTH = 2**TX_DEPTH_W;
  localparam int RX_DEPTH = 2**RX_DEPTH_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_GAP  = 1'b1;

  // ---------------------------------------------------------------------------
  // TX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKT_W-1:0]   r_tx_mem [TX_DEPTH];
  logic [TX_DEPTH_W:0] r_tx_wptr;
  logic [TX_DEPTH_W:0] r_tx_rptr;
  logic                w_tx_full;
  logic                w_tx_empty;
  logic                w_tx_push;
  logic                w_tx_pop;

  assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
  assign w_tx_full  = (r_tx_wptr[TX_DEPTH_W] != r_tx_rptr[TX_DEPTH_W]) &&
                      (r_tx_wptr[TX_DEPTH_W-1:0] == r_tx_rptr[TX_DEPTH_W-1:0]);
  assign w_tx_push  = tx_valid_i && !w_tx_full;
  assign tx_ready_o = !w_tx_full;

  always_ff @(posedge clk_i) begin
    if (w_tx_push) begin
      r_tx_mem[r_tx_wptr[TX_DEPTH_W-1:0]] <= {tx_row_i, tx_col_i, tx_data_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tx_wptr <= '0;
      r_tx_rptr <= '0;
    end else begin
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + (TX_DEPTH_W+1)'(1);
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + (TX_DEPTH_W+1)'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // TX injection FSM
  // ---------------------------------------------------------------------------
  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [PCKT_W-1:0] r_noc_pckt;
  logic              r_noc_wren;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (!w_tx_empty && !noc_full_i) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // GAP idles one cycle so the NoC's registered full flag reflects our last write
  always_comb begin
    w_tx_pop = 1'b0;
    if (r_state == S_IDLE && !w_tx_empty && !noc_full_i) w_tx_pop = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_noc_wren <= 1'b0;
      r_noc_pckt <= '0;
    end else begin
      r_noc_wren <= w_tx_pop;
      if (w_tx_pop) r_noc_pckt <= r_tx_mem[r_tx_rptr[TX_DEPTH_W-1:0]];
    end
  end

  assign noc_wren_o = r_noc_wren;
  assign noc_pckt_o = r_noc_pckt;

  // ---------------------------------------------------------------------------
  // Sticky NoC overflow error
  // ---------------------------------------------------------------------------
  logic r_err_ovrflw;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_err_ovrflw <= 1'b0;
    else         r_err_ovrflw <= r_err_ovrflw | noc_ovrflw_i;
  end

  assign err_ovrflw_o = r_err_ovrflw;

  // ---------------------------------------------------------------------------
  // RX FIFO
  // ---------------------------------------------------------------------------
  logic [PCKT_W-1:0]   r_rx_mem [RX_DEPTH];
  logic [RX_DEPTH_W:0] r_rx_wptr;
  logic [RX_DEPTH_W:0] r_rx_rptr;
  logic                w_rx_full;
  logic                w_rx_empty;
  logic                w_rx_push;
  logic                w_rx_pop;
  logic                r_rsc_ovrflw;
  logic [PCKT_W-1:0]   w_rx_head;

  assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
  assign w_rx_full  = (r_rx_wptr[RX_DEPTH_W] != r_rx_rptr[RX_DEPTH_W]) &&
                      (r_rx_wptr[RX_DEPTH_W-1:0] == r_rx_rptr[RX_DEPTH_W-1:0]);
  // Full is judged before any same-cycle pop, so a write into a full FIFO is always lost
  assign w_rx_push  = noc_wren_i && !w_rx_full;
  assign w_rx_pop   = !w_rx_empty && rx_ready_i;

  always_ff @(posedge clk_i) begin
    if (w_rx_push) begin
      r_rx_mem[r_rx_wptr[RX_DEPTH_W-1:0]] <= noc_pckt_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_wptr    <= '0;
      r_rx_rptr    <= '0;
      r_rsc_ovrflw <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + (RX_DEPTH_W+1)'(1);
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + (RX_DEPTH_W+1)'(1);
      r_rsc_ovrflw <= noc_wren_i && w_rx_full;
    end
  end

  assign w_rx_head    = r_rx_mem[r_rx_rptr[RX_DEPTH_W-1:0]];
  assign rx_valid_o   = !w_rx_empty;
  assign rx_row_o     = w_rx_head[PCKT_W-1 -: ROW_W];
  assign rx_col_o     = w_rx_head[PCKT_DATA_W+COL_W-1 -: COL_W];
  assign rx_data_o    = w_rx_head[PCKT_DATA_W-1:0];
  assign rsc_full_o   = w_rx_full;
  assign rsc_ovrflw_o = r_rsc_ovrflw;

endmodule
`default_nettype wire

// File: tb/tb_noc_rsc_adapter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_noc_rsc_adapter                                           |
// | Description : Scoreboard bench for noc_rsc_adapter TX/RX paths.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_noc_rsc_adapter;

  localparam int ROW_W  = 2;
  localparam int COL_W  = 2;
  localparam int DATA_W = 8;
  localparam int PCKT_W = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tx_valid_i;
  logic              tx_ready_o;
  logic [ROW_W-1:0]  tx_row_i;
  logic [COL_W-1:0]  tx_col_i;
  logic [DATA_W-1:0] tx_data_i;
  logic [PCKT_W-1:0] noc_pckt_o;
  logic              noc_wren_o;
  logic              noc_full_i;
  logic              noc_ovrflw_i;
  logic [PCKT_W-1:0] noc_pckt_i;
  logic              noc_wren_i;
  logic              rsc_full_o;
  logic              rsc_ovrflw_o;
  logic              rx_valid_o;
  logic              rx_ready_i;
  logic [DATA_W-1:0] rx_data_o;
  logic [ROW_W-1:0]  rx_row_o;
  logic [COL_W-1:0]  rx_col_o;
  logic              err_ovrflw_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [PCKT_W-1:0] tx_q [$];
  logic [PCKT_W-1:0] rx_q [$];

  always #5 clk = ~clk;

  noc_rsc_adapter dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_valid_i   (tx_valid_i),
    .tx_ready_o   (tx_ready_o),
    .tx_row_i     (tx_row_i),
    .tx_col_i     (tx_col_i),
    .tx_data_i    (tx_data_i),
    .noc_pckt_o   (noc_pckt_o),
    .noc_wren_o   (noc_wren_o),
    .noc_full_i   (noc_full_i),
    .noc_ovrflw_i (noc_ovrflw_i),
    .noc_pckt_i   (noc_pckt_i),
    .noc_wren_i   (noc_wren_i),
    .rsc_full_o   (rsc_full_o),
    .rsc_ovrflw_o (rsc_ovrflw_o),
    .rx_valid_o   (rx_valid_o),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .rx_row_o     (rx_row_o),
    .rx_col_o     (rx_col_o),
    .err_ovrflw_o (err_ovrflw_o)
  );

  function automatic logic [PCKT_W-1:0] pk(input int r, input int c, input int d);
    logic [ROW_W-1:0]  rr;
    logic [COL_W-1:0]  cc;
    logic [DATA_W-1:0] dd;
    rr = ROW_W'(r);
    cc = COL_W'(c);
    dd = DATA_W'(d);
    return {rr, cc, dd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tx_valid_i = 0; tx_row_i = '0; tx_col_i = '0; tx_data_i = '0;
    noc_full_i = 0; noc_ovrflw_i = 0; noc_pckt_i = '0; noc_wren_i = 0; rx_ready_i = 0;
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({noc_wren_o, noc_pckt_o, rsc_ovrflw_o, err_ovrflw_o, tx_ready_o, rx_valid_o, rsc_full_o}
        !== {1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: got wren=%b pckt=%h ovf=%b err=%b rdy=%b rxv=%b full=%b, want 0 000 0 0 1 0 0",
               noc_wren_o, noc_pckt_o, rsc_ovrflw_o, err_ovrflw_o, tx_ready_o, rx_valid_o, rsc_full_o);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_tx();
    logic [PCKT_W-1:0] exp;
    noc_full_i = 0;
    tx_valid_i = 1; tx_row_i = 2'd2; tx_col_i = 2'd1; tx_data_i = 8'hA5;
    tx_q.push_back(12'h9A5);
    tick();
    tx_valid_i = 0;
    n_tests++;
    if (noc_wren_o !== 1'b0) begin
      n_fail++; $display("FAIL single_tx_no_early_strobe: wren=%b want 0", noc_wren_o);
    end
    tick();
    exp = tx_q.pop_front();
    n_tests++;
    if (noc_wren_o !== 1'b1 || noc_pckt_o !== exp) begin
      n_fail++; $display("FAIL single_tx_strobe: wren=%b pckt=%h want 1 %h", noc_wren_o, noc_pckt_o, exp);
    end
    tick();
    n_tests++;
    if (noc_wren_o !== 1'b0 || noc_pckt_o !== exp) begin
      n_fail++; $display("FAIL single_tx_gap_hold: wren=%b pckt=%h want 0 %h", noc_wren_o, noc_pckt_o, exp);
    end
  endtask

  task automatic test_tx_backpressure();
    logic [PCKT_W-1:0] exp;
    int strobes = 0;
    int got = 0;
    int last = -1;
    noc_full_i = 1;
    for (int i = 0; i < 4; i++) begin
      tx_valid_i = 1;
      {tx_row_i, tx_col_i, tx_data_i} = pk(i % 3, 2 - (i % 3), 8'h10 + i);
      tx_q.push_back(pk(i % 3, 2 - (i % 3), 8'h10 + i));
      tick();
      if (noc_wren_o) strobes++;
    end
    tx_valid_i = 0;
    n_tests++;
    if (tx_ready_o !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low: tx_ready=%b want 0", tx_ready_o);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      if (noc_wren_o) strobes++;
    end
    n_tests++;
    if (strobes != 0) begin
      n_fail++; $display("FAIL bp_no_strobe: strobes=%0d want 0", strobes);
    end
    noc_full_i = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (noc_wren_o) begin
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
        n_tests++;
        if (noc_pckt_o !== exp) begin
          n_fail++; $display("FAIL bp_order: pckt=%h want %h", noc_pckt_o, exp);
        end
        if (last >= 0) begin
          n_tests++;
          if (c - last != 2) begin
            n_fail++; $display("FAIL bp_spacing: gap=%0d want 2", c - last);
          end
        end
        last = c;
        got++;
      end
    end
    n_tests++;
    if (got != 4 || tx_ready_o !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain: strobes=%0d ready=%b want 4 1", got, tx_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [PCKT_W-1:0] exp;
    logic [PCKT_W-1:0] pkt;
    logic acc;
    int sent = 0;
    int got = 0;
    int last = -1;
    noc_full_i = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      pkt = pk(sent % 3, (sent + 1) % 3, 8'h30 + sent);
      tx_valid_i = (sent < 6);
      {tx_row_i, tx_col_i, tx_data_i} = pkt;
      acc = tx_valid_i && tx_ready_o;
      tick();
      if (acc) begin
        tx_q.push_back(pkt);
        sent++;
      end
      if (noc_wren_o) begin
        exp = (tx_q.size() > 0) ? tx_q.pop_front() : 'x;
        n_tests++;
        if (noc_pckt_o !== exp) begin
          n_fail++; $display("FAIL b2b_order: pckt=%h want %h", noc_pckt_o, exp);
        end
        if (last >= 0) begin
          n_tests++;
          if (c - last != 2) begin
            n_fail++; $display("FAIL b2b_spacing: gap=%0d want 2", c - last);
          end
        end
        last = c;
        got++;
      end
    end
    tx_valid_i = 0;
    n_tests++;
    if (got != 6) begin
      n_fail++; $display("FAIL b2b_count: strobes=%0d want 6 (timeout)", got);
    end
  endtask

  task automatic test_rx_overflow();
    logic [PCKT_W-1:0] exp;
    rx_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      noc_wren_i = 1;
      noc_pckt_i = pk(i % 3, (i + 2) % 3, 8'hC0 + i);
      if (i < 4) rx_q.push_back(noc_pckt_i);
      n_tests++;
      if (rsc_full_o !== (i == 4)) begin
        n_fail++; $display("FAIL rx_full_flag[%0d]: full=%b want %b", i, rsc_full_o, (i == 4));
      end
      tick();
      n_tests++;
      if (rsc_ovrflw_o !== (i == 4)) begin
        n_fail++; $display("FAIL rx_ovrflw[%0d]: ovrflw=%b want %b", i, rsc_ovrflw_o, (i == 4));
      end
    end
    noc_wren_i = 0;
    tick();
    n_tests++;
    if (rsc_ovrflw_o !== 1'b0) begin
      n_fail++; $display("FAIL rx_ovrflw_pulse: ovrflw=%b want 0", rsc_ovrflw_o);
    end
    rx_ready_i = 1;
    for (int k = 0; k < 4; k++) begin
      exp = rx_q.pop_front();
      n_tests++;
      if (rx_valid_o !== 1'b1 || {rx_row_o, rx_col_o, rx_data_o} !== exp) begin
        n_fail++; $display("FAIL rx_drain[%0d]: valid=%b head=%h want 1 %h",
                           k, rx_valid_o, {rx_row_o, rx_col_o, rx_data_o}, exp);
      end
      tick();
    end
    rx_ready_i = 0;
    n_tests++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL rx_empty_after_drain: valid=%b want 0", rx_valid_o);
    end
  endtask

  task automatic test_simultaneous();
    logic [PCKT_W-1:0] exp;
    rx_ready_i = 0;
    for (int i = 0; i < 4; i++) begin
      noc_wren_i = 1;
      noc_pckt_i = pk(2, i % 3, 8'h50 + i);
      rx_q.push_back(noc_pckt_i);
      tick();
    end
    noc_wren_i = 1;
    noc_pckt_i = pk(1, 1, 8'hEE);
    rx_ready_i = 1;
    exp = rx_q.pop_front();
    n_tests++;
    if (rsc_full_o !== 1'b1 || {rx_row_o, rx_col_o, rx_data_o} !== exp) begin
      n_fail++; $display("FAIL sim_pre: full=%b head=%h want 1 %h", rsc_full_o, {rx_row_o, rx_col_o, rx_data_o}, exp);
    end
    tick();
    noc_wren_i = 0;
    rx_ready_i = 0;
    n_tests++;
    if (rsc_ovrflw_o !== 1'b1 || rsc_full_o !== 1'b0) begin
      n_fail++; $display("FAIL sim_post: ovrflw=%b full=%b want 1 0", rsc_ovrflw_o, rsc_full_o);
    end
    rx_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      exp = rx_q.pop_front();
      n_tests++;
      if (rx_valid_o !== 1'b1 || {rx_row_o, rx_col_o, rx_data_o} !== exp) begin
        n_fail++; $display("FAIL sim_drain[%0d]: valid=%b head=%h want 1 %h",
                           k, rx_valid_o, {rx_row_o, rx_col_o, rx_data_o}, exp);
      end
      tick();
    end
    rx_ready_i = 0;
    n_tests++;
    if (rx_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL sim_dropped_push: valid=%b want 0", rx_valid_o);
    end
  endtask

  task automatic test_error();
    n_tests++;
    if (err_ovrflw_o !== 1'b0) begin
      n_fail++; $display("FAIL err_initial: err=%b want 0", err_ovrflw_o);
    end
    noc_ovrflw_i = 1;
    tick();
    noc_ovrflw_i = 0;
    n_tests++;
    if (err_ovrflw_o !== 1'b1) begin
      n_fail++; $display("FAIL err_set: err=%b want 1", err_ovrflw_o);
    end
    for (int i = 0; i < 5; i++) tick();
    n_tests++;
    if (err_ovrflw_o !== 1'b1) begin
      n_fail++; $display("FAIL err_sticky: err=%b want 1", err_ovrflw_o);
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0;
    int rxv = 0;
    noc_full_i = 1;
    rx_ready_i = 0;
    for (int i = 0; i < 2; i++) begin
      tx_valid_i = 1;
      {tx_row_i, tx_col_i, tx_data_i} = pk(1, 2, 8'h70 + i);
      noc_wren_i = 1;
      noc_pckt_i = pk(0, 1, 8'h80 + i);
      tick();
    end
    tx_valid_i = 0;
    noc_wren_i = 0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({noc_wren_o, noc_pckt_o, rsc_ovrflw_o, err_ovrflw_o, tx_ready_o, rx_valid_o, rsc_full_o}
        !== {1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_values: got wren=%b pckt=%h ovf=%b err=%b rdy=%b rxv=%b full=%b, want 0 000 0 0 1 0 0",
               noc_wren_o, noc_pckt_o, rsc_ovrflw_o, err_ovrflw_o, tx_ready_o, rx_valid_o, rsc_full_o);
    end
    tick();
    rst_n = 1'b1;
    noc_full_i = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (noc_wren_o) strobes++;
      if (rx_valid_o) rxv++;
    end
    n_tests++;
    if (strobes != 0 || rxv != 0) begin
      n_fail++; $display("FAIL reset_mid_discard: tx_strobes=%0d rx_valid_cycles=%0d want 0 0", strobes, rxv);
    end
  endtask

  initial begin
    test_reset();
    test_single_tx();
    test_tx_backpressure();
    test_back_to_back();
    test_rx_overflow();
    test_simultaneous();
    test_error();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
